// File: rtl/micro_op_picker.sv
// micro_op_picker: buffers one decode group of micro-op slots and emits the
// valid ones in ascending slot order, compacted into OUT_WIDTH lanes per cycle.
// Decode is held off until the buffered group has fully drained.
module micro_op_picker #(
   parameter int DECODE_WIDTH = 2,
   parameter int MOP_MAX      = 3,
   parameter int OUT_WIDTH    = 2,
   parameter int INFO_W       = 64,
   localparam int ALL_W       = DECODE_WIDTH * MOP_MAX
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ALL_W-1:0]          in_mop_valid,
   input  logic [ALL_W*INFO_W-1:0]   in_mop_info,
   input  logic                      out_stall,
   output logic [OUT_WIDTH-1:0]      out_valid,
   output logic [OUT_WIDTH*INFO_W-1:0] out_info,
   output logic                      out_group_end
);

   // Wide enough to hold any slot rank and the lane count without truncation.
   localparam int RW = $clog2(ALL_W + OUT_WIDTH + 1);

   logic [ALL_W-1:0]                pending_reg;
   logic [ALL_W-1:0]                pending_next;
   logic [ALL_W-1:0]                picked;
   logic [ALL_W*INFO_W-1:0]         info_reg;
   logic [ALL_W-1:0][RW-1:0]        rank;
   logic [RW-1:0]                   pop_count;
   logic [OUT_WIDTH-1:0][ALL_W-1:0] lane_sel;
   logic [INFO_W-1:0][ALL_W-1:0]    info_t;
   logic                            accept;

   // Per-slot rank = number of pending slots below it; a slot with rank n
   // lands on lane n. Slots whose rank reaches OUT_WIDTH wait for a later cycle.
   genvar gi, gj, gk;
   generate
      for (gi = 0; gi < ALL_W; gi++) begin : g_slot
         if (gi == 0) begin : g_first
            assign rank[gi] = '0;
         end else begin : g_rest
            assign rank[gi] = RW'($countones(pending_reg[gi-1:0]));
         end
         assign picked[gi] = pending_reg[gi] && (rank[gi] < RW'(OUT_WIDTH));
         // Transpose the payload so each output bit is a one-hot AND-OR.
         for (gk = 0; gk < INFO_W; gk++) begin : g_bit
            assign info_t[gk][gi] = info_reg[gi*INFO_W + gk];
         end
      end

      for (gj = 0; gj < OUT_WIDTH; gj++) begin : g_lane
         for (gi = 0; gi < ALL_W; gi++) begin : g_sel
            assign lane_sel[gj][gi] = pending_reg[gi] && (rank[gi] == RW'(gj));
         end
         assign out_valid[gj] = |lane_sel[gj];
         // At most one select bit is set, so unused lanes read as zero.
         for (gk = 0; gk < INFO_W; gk++) begin : g_obit
            assign out_info[gj*INFO_W + gk] = |(lane_sel[gj] & info_t[gk]);
         end
      end
   endgenerate

   assign pop_count     = RW'($countones(pending_reg));
   assign out_group_end = (pending_reg != '0) && (pop_count <= RW'(OUT_WIDTH));

   // Accepting while the last lanes drain gives back-to-back groups with no
   // bubble; this makes in_ready depend combinationally on out_stall.
   assign in_ready = !flush && ((pending_reg == '0) || (out_group_end && !out_stall));
   assign accept   = in_valid && in_ready;

   // Next pending mask: flush wins, then a new group, then normal advance.
   always_comb begin
      pending_next = pending_reg;
      if (flush) begin
         pending_next = '0;
      end else if (accept) begin
         pending_next = in_mop_valid;
      end else if (!out_stall) begin
         pending_next = pending_reg & ~picked;
      end
   end

   // Pending mask register; clearing it is all that is needed to empty the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_reg <= '0;
      end else begin
         pending_reg <= pending_next;
      end
   end

   // Payload store; contents only matter for slots marked pending.
   always_ff @(posedge clk) begin
      if (accept) begin
         info_reg <= in_mop_info;
      end
   end

endmodule
